// File: rtl/uart_pkg.sv
// Definitions shared by the uart transmitter and the arbiter that feeds it.
package uart_pkg;

  // Byte width of the uart data path.
  localparam int unsigned DEF_DATA_W = 8;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic             found_o
);

  // Walk candidates in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    pick_o  = '0;
    found_o = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found_o && req_i[i] && (((32'(ptr_i) + k) % N_REQ) == i)) begin
          pick_o[i] = 1'b1;
          found_o   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart transmitter among N_REQ sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned HOLD_TIMEOUT = 1023
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ack,
  output logic [N_REQ-1:0]          gnt,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done_tick,
  output logic                      busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_TIMEOUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    req_ack_q, req_ack_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                busy_q, busy_d;

  logic [N_REQ-1:0]    pick;
  logic                pick_found;
  logic [PTR_W-1:0]    owner_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_last;
  logic                owner_req;
  logic [CNT_W-1:0]    cnt_inc;
  logic                rel;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .found_o (pick_found)
  );

  // Decode the current owner: its index and its offered byte.
  always_comb begin
    owner_idx = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        owner_idx = PTR_W'(i);
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign owner_req = |(gnt_q & req);
  assign sel_last  = |(gnt_q & req_last);
  // Pointer moves past the releasing owner so no waiting source is starved.
  assign next_ptr  = (owner_idx == PTR_LAST) ? '0 : owner_idx + PTR_W'(1);
  // Hold counter saturates rather than wrapping.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    req_ack_d  = '0;
    rel        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d   = pick;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_start_d = 1'b1;
        tx_data_d  = sel_data;
        req_ack_d  = gnt_q;
        last_d     = sel_last;
        state_d    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Owner req changes are only looked at once the byte is out.
        if (tx_done_tick) begin
          if (last_q) begin
            rel = 1'b1;
          end else if (owner_req) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (owner_req) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            rel = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rel) begin
      gnt_d   = '0;
      ptr_d   = next_ptr;
      state_d = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      req_ack_q  <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      req_ack_q  <= req_ack_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign req_ack  = req_ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing the single `uart` transmitter among `N_REQ` byte-stream requesters. Grants one requester at a time and keeps the grant locked for a whole packet, ending at the byte flagged `req_last`. Sequences the transmitter through a start/done handshake. Sits between the system's message sources (status reporter, echo path, LED/debug dump) and the `tx` side of `uart`.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters, range 2..8.
- `DATA_W`, 8: byte width, matches the `uart` `w_data` width.
- `HOLD_TIMEOUT`, 1023: clocks a locked grant waits for the next byte before it is released.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `req`, in, `N_REQ`: per-requester byte valid.
- `req_data`, in, `N_REQ*DATA_W`: requester i's byte is bits `[i*DATA_W +: DATA_W]`.
- `req_last`, in, `N_REQ`: the offered byte ends the packet.
- `req_ack`, out, `N_REQ`: one-cycle pulse, the byte of requester i was accepted.
- `gnt`, out, `N_REQ`: one-hot current owner, all zero when free.
- `tx_start`, out, 1: one-cycle pulse that starts the transmitter.
- `tx_data`, out, `DATA_W`: byte to send, stable from `tx_start` until `tx_done_tick`.
- `tx_done_tick`, in, 1: one-cycle pulse from the transmitter when the stop bit completes.
- `busy`, out, 1: high in every state except IDLE.

## Operation

- **States:**
  - IDLE, LOAD, WAIT_DONE, HOLD.
  - Reset (asynchronous, `reset`=0) forces IDLE.
  - Reset values: `gnt`=0, `req_ack`=0, `tx_start`=0, `tx_data`=0, `busy`=0, rr pointer=0, timeout counter=0.
- **IDLE:**
  - If `req` is nonzero, pick the first set bit searching upward from the rr pointer and wrapping at `N_REQ-1`→0.
  - Register `gnt` one-hot and go to LOAD.
- **LOAD** (one cycle):
  - Assert `tx_start`.
  - Register `tx_data` from the granted slice.
  - Pulse the granted `req_ack` bit.
  - Latch the granted `req_last` into `last_q`.
  - Go to WAIT_DONE.
- **WAIT_DONE:** on `tx_done_tick`:
  - If `last_q`=1: clear `gnt`, set the rr pointer to owner+1 (mod `N_REQ`), go to IDLE.
  - Else, if the owner's `req`=1: go to LOAD.
  - Else: go to HOLD and clear the timeout counter.
- **HOLD:**
  - Grant stays locked and other requesters are ignored.
  - Owner `req`=1: go to LOAD.
  - Counter reaches `HOLD_TIMEOUT`: release exactly as on a last byte.
  - The counter saturates and never wraps.
- **Requester contract:** `req_data` and `req_last` are held stable while `req`=1 until `req_ack`. The arbiter does not check this.
- **Boundaries:**
  - A `tx_done_tick` outside WAIT_DONE is ignored. This covers ticks arriving in the LOAD cycle itself.
  - Owner `req` dropping during WAIT_DONE has no effect until the done tick.
  - A requester whose `req` rises while another owns the grant waits. It cannot be starved: after release the pointer moves past the old owner.
  - A single-byte packet (`req_last`=1 on the first byte) is legal.

## Timing

- `req` sampled high in IDLE at edge k gives `gnt` valid after k, then `tx_start`/`req_ack` high for cycle k+1..k+2.
- Latency from request to `tx_start` is 2 clocks.
- Back-to-back bytes of one packet: `tx_done_tick` at edge d gives the next `tx_start` after d+1. The inter-byte gap is 1 clock.
- Release: `tx_done_tick` of the last byte at d makes `gnt` zero after d. A new grant is visible after d+1.
- Outputs are all registered and no output depends combinationally on an input.

## Structure

- Shared package `uart_pkg`: state encoding (`ST_IDLE`, `ST_LOAD`, `ST_WAIT_DONE`, `ST_HOLD`) and the default `DATA_W`=8, shared with `uart`.
- One sub-module, `rr_pick`: combinational round-robin picker that takes `req` and the pointer and produces a one-hot result and a found flag. This keeps the FSM file to state, counter and registers.

## Test plan

- **Reset mid-packet:** drive `reset`=0 while in WAIT_DONE. All outputs go to 0 immediately and asynchronously. After release, `req`=4'b0001 gives `tx_start` 2 clocks later.
- **Single requester, 3-byte packet:** requester 0 sends 8'hC3, 8'h55, 8'hAA with last on 8'hAA, and the bench model returns `tx_done_tick` 20 clocks after each start. Expect `tx_data` to show those three values, three `req_ack[0]` pulses, `gnt`=0001 throughout, then `gnt`=0.
- **Round robin:** hold `req`=4'b1111 with every byte last. Grants appear in the order 0001, 0010, 0100, 1000, 0001.
- **Packet lock:** requester 1 is mid-packet when `req[3]` rises. `gnt` stays 0010 until requester 1's last byte, then goes to 1000.
- **Hold timeout:** with `HOLD_TIMEOUT`=15, the owner drops `req` after a non-last byte and never returns. `gnt` clears 15 clocks after entering HOLD and requester 2 is granted next.
- **Spurious done:** pulse `tx_done_tick` during IDLE and during the LOAD cycle. No state change occurs and no extra `tx_start` is issued.
